vote_button_conditioner: RTL and testbench

- Upstream stage of the vote logger.
- Converts four raw, asynchronous, bouncing candidate push-buttons into clean single-cycle candN_vote_valid pulses.
- Each pulse represents exactly one accepted press. Simultaneous presses are rejected, and a press-release-lockout sequence prevents one press from being counted twice.

---
 rtl/vote_button_conditioner_if.sv | 61 ++++++
 rtl/vote_button_conditioner.sv | 171 +++++++++++++++++
 tb/tb_vote_button_conditioner.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/vote_button_conditioner_if.sv
// ---------------------------------------------------------------------------
// vote_button_conditioner_if
//   Bundle between the raw candidate buttons / mode switch and the vote
//   logger. The conditioner connects through the slave modport; whoever
//   drives the buttons and consumes the vote pulses uses the master modport.
//
//   Signals:
//     mode               0 = voting, 1 = result/display (clock-synchronous)
//     candN_button       raw, asynchronous, bouncing push-buttons (N = 1..4)
//     candN_vote_valid   one-cycle accepted-vote pulses
//     busy               conditioner FSM is not idle
//     reject_count       8-bit saturating rejection counter
//                        (present only with VOTE_REJECT_CNT_EN defined)
// ---------------------------------------------------------------------------
interface vote_button_conditioner_if;
    logic       mode;
    logic       cand1_button;
    logic       cand2_button;
    logic       cand3_button;
    logic       cand4_button;
    logic       cand1_vote_valid;
    logic       cand2_vote_valid;
    logic       cand3_vote_valid;
    logic       cand4_vote_valid;
    logic       busy;
`ifdef VOTE_REJECT_CNT_EN
    logic [7:0] reject_count;
`endif

    modport master (
        output mode,
        output cand1_button,
        output cand2_button,
        output cand3_button,
        output cand4_button,
        input  cand1_vote_valid,
        input  cand2_vote_valid,
        input  cand3_vote_valid,
        input  cand4_vote_valid,
        input  busy
`ifdef VOTE_REJECT_CNT_EN
        , input reject_count
`endif
    );

    modport slave (
        input  mode,
        input  cand1_button,
        input  cand2_button,
        input  cand3_button,
        input  cand4_button,
        output cand1_vote_valid,
        output cand2_vote_valid,
        output cand3_vote_valid,
        output cand4_vote_valid,
        output busy
`ifdef VOTE_REJECT_CNT_EN
        , output reject_count
`endif
    );
endinterface

// File: rtl/vote_button_conditioner.sv
// ---------------------------------------------------------------------------
// vote_button_conditioner
//   Turns four raw, bouncing candidate buttons into clean single-cycle vote
//   pulses. Each button is double-flop synchronised; a single FSM debounces
//   one press at a time, rejects simultaneous presses, waits for full
//   release and then enforces a lockout before accepting the next press.
//
//   Ports:
//     clock   system clock
//     reset   asynchronous, active-high reset (clears all state)
//     bus     vote_button_conditioner_if.slave:
//               mode, cand1..4_button            (in)
//               cand1..4_vote_valid, busy        (out)
//               reject_count                     (out, optional)
//
//   Optional feature macro: VOTE_REJECT_CNT_EN
//     When defined, adds an 8-bit saturating count of rejection events.
// ---------------------------------------------------------------------------
module vote_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int CNT_W           = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    vote_button_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] DEB_TERM  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCKOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PULSE,
        ST_WAIT_RELEASE,
        ST_LOCKOUT
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [3:0]       w_raw;
    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_idx;
    logic [3:0]       r_valid;
    logic             r_busy;
    logic             w_one;
    logic             w_multi;
    logic [1:0]       w_idx;
    logic             w_latched_hi;
    logic             w_other_hi;
`ifdef VOTE_REJECT_CNT_EN
    logic [7:0]       r_reject;
`endif

    assign w_raw = {bus.cand4_button, bus.cand3_button,
                    bus.cand2_button, bus.cand1_button};

    // Synchroniser stage: raw -> sync1 -> sync2
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_one        = $onehot(r_sync2);
        w_multi      = (r_sync2 != 4'b0000) && !w_one;
        w_idx        = 2'd0;
        if (r_sync2[1]) w_idx = 2'd1;
        if (r_sync2[2]) w_idx = 2'd2;
        if (r_sync2[3]) w_idx = 2'd3;
        w_latched_hi = r_sync2[r_idx];
        w_other_hi   = |(r_sync2 & ~(4'b0001 << r_idx));
    end

    // Control FSM stage: outputs are registered alongside the state so the
    // valid pulse coincides exactly with the PULSE state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_valid  <= 4'b0000;
            r_busy   <= 1'b0;
`ifdef VOTE_REJECT_CNT_EN
            r_reject <= 8'd0;
`endif
        end else begin
            r_valid <= 4'b0000;
            case (r_state)
                ST_IDLE: begin
                    if (!bus.mode && w_one) begin
                        r_idx   <= w_idx;
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_DEBOUNCE;
                        r_busy  <= 1'b1;
                    end else if (!bus.mode && w_multi) begin
                        r_state  <= ST_WAIT_RELEASE;
                        r_busy   <= 1'b1;
`ifdef VOTE_REJECT_CNT_EN
                        r_reject <= sat_inc8(r_reject);
`endif
                    end
                end
                ST_DEBOUNCE: begin
                    if (bus.mode || !w_latched_hi) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_other_hi) begin
                        r_state  <= ST_WAIT_RELEASE;
`ifdef VOTE_REJECT_CNT_EN
                        r_reject <= sat_inc8(r_reject);
`endif
                    end else if (r_cnt == DEB_TERM) begin
                        r_state <= ST_PULSE;
                        r_valid <= 4'b0001 << r_idx;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    r_state <= ST_WAIT_RELEASE;
                end
                ST_WAIT_RELEASE: begin
                    if (r_sync2 == 4'b0000) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_LOCKOUT;
                    end
                end
                ST_LOCKOUT: begin
                    if (r_cnt == LOCK_TERM) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef VOTE_REJECT_CNT_EN
    // Saturation helper is only used by the optional counter.
    logic [7:0] w_unused_sat;
    assign w_unused_sat = sat_inc8(8'd0);
`endif

    assign bus.cand1_vote_valid = r_valid[0];
    assign bus.cand2_vote_valid = r_valid[1];
    assign bus.cand3_vote_valid = r_valid[2];
    assign bus.cand4_vote_valid = r_valid[3];
    assign bus.busy             = r_busy;
`ifdef VOTE_REJECT_CNT_EN
    assign bus.reject_count     = r_reject;
`endif

endmodule

// File: tb/tb_vote_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_vote_button_conditioner
//   Directed bench for vote_button_conditioner with DEBOUNCE_CYCLES=4,
//   LOCKOUT_CYCLES=3. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point; pulses are tallied per candidate
//   on the falling edge.
// ---------------------------------------------------------------------------
module tb_vote_button_conditioner;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   failed;
    int   pc [1:4];
    int   multi_hot;
    int   base;

    vote_button_conditioner_if vif ();

    vote_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .LOCKOUT_CYCLES  (3),
        .CNT_W           (8)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        int n;
        n = int'(vif.cand1_vote_valid) + int'(vif.cand2_vote_valid) +
            int'(vif.cand3_vote_valid) + int'(vif.cand4_vote_valid);
        if (n > 1) multi_hot++;
        if (vif.cand1_vote_valid) pc[1]++;
        if (vif.cand2_vote_valid) pc[2]++;
        if (vif.cand3_vote_valid) pc[3]++;
        if (vif.cand4_vote_valid) pc[4]++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] vv();
        return {28'd0, vif.cand4_vote_valid, vif.cand3_vote_valid,
                vif.cand2_vote_valid, vif.cand1_vote_valid};
    endfunction

    function automatic logic [31:0] bz();
        return {31'd0, vif.busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0; passed = 0; failed = 0; multi_hot = 0;
        for (int i = 1; i <= 4; i++) pc[i] = 0;
        rst = 1'b1;
        vif.mode = 1'b0;
        vif.cand1_button = 1'b0;
        vif.cand2_button = 1'b0;
        vif.cand3_button = 1'b0;
        vif.cand4_button = 1'b0;

        // Reset state
        tick(3);
        chk("reset_busy", bz(), 0);
        chk("reset_valid", vv(), 0);
`ifdef VOTE_REJECT_CNT_EN
        chk("reset_reject", {24'd0, vif.reject_count}, 0);
`endif
        rst = 1'b0;
        tick(2);

        // 1. Clean press on cand2, pulse after tick 7
        vif.cand2_button = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("t1_pre_pulse", vv(), 0);
        end
        tick(1);
        chk("t1_pulse", vv(), 2);
        chk("t1_busy", bz(), 1);
        tick(1);
        chk("t1_single_cycle", vv(), 0);
        tick(12);
        vif.cand2_button = 1'b0;
        tick(5);
        chk("t1_busy_lockout", bz(), 1);
        tick(1);
        chk("t1_idle", bz(), 0);
        chk("t1_count2", pc[2], 1);
        chk("t1_others", pc[1] + pc[3] + pc[4], 0);

        // 2. Bounce then stable hold on cand1
        base = pc[1];
        repeat (4) begin
            vif.cand1_button = 1'b1;
            tick(2);
            vif.cand1_button = 1'b0;
            tick(1);
        end
        chk("t2_bounce_nopulse", pc[1] - base, 0);
        vif.cand1_button = 1'b1;
        tick(6);
        chk("t2_pre_pulse", pc[1] - base, 0);
        tick(1);
        chk("t2_pulse", vv(), 1);
        tick(3);
        vif.cand1_button = 1'b0;
        chk("t2_count", pc[1] - base, 1);
        tick(8);
        chk("t2_idle", bz(), 0);

        // 3. Simultaneous cand3 + cand4
        base = pc[3] + pc[4];
        vif.cand3_button = 1'b1;
        vif.cand4_button = 1'b1;
        tick(2);
        chk("t3_busy_before", bz(), 0);
        tick(1);
        chk("t3_busy_reject", bz(), 1);
        tick(7);
        chk("t3_no_pulse", pc[3] + pc[4] - base, 0);
`ifdef VOTE_REJECT_CNT_EN
        chk("t3_reject_count", {24'd0, vif.reject_count}, 1);
`endif
        vif.cand3_button = 1'b0;
        vif.cand4_button = 1'b0;
        tick(8);
        chk("t3_idle", bz(), 0);

        // 4a. Long hold, short re-press inside lockout
        base = pc[1];
        vif.cand1_button = 1'b1;
        tick(50);
        chk("t4a_first", pc[1] - base, 1);
        vif.cand1_button = 1'b0;
        tick(1);
        vif.cand1_button = 1'b1;
        tick(2);
        vif.cand1_button = 1'b0;
        tick(12);
        chk("t4a_repress_ignored", pc[1] - base, 1);
        chk("t4a_idle", bz(), 0);

        // 4b. Long hold, long re-press: second pulse after lockout
        base = pc[1];
        vif.cand1_button = 1'b1;
        tick(50);
        vif.cand1_button = 1'b0;
        tick(1);
        vif.cand1_button = 1'b1;
        tick(9);
        chk("t4b_pre_second", vv(), 0);
        tick(1);
        chk("t4b_second", vv(), 1);
        tick(10);
        chk("t4b_count", pc[1] - base, 2);
        vif.cand1_button = 1'b0;
        tick(8);

        // 5. mode held high, then mode rising mid-debounce
        base = pc[2];
        vif.mode = 1'b1;
        vif.cand2_button = 1'b1;
        tick(3);
        chk("t5_busy_mode", bz(), 0);
        tick(17);
        chk("t5_busy_mode_end", bz(), 0);
        chk("t5_no_pulse", pc[2] - base, 0);
        vif.cand2_button = 1'b0;
        tick(3);
        vif.mode = 1'b0;
        tick(2);
        vif.cand2_button = 1'b1;
        tick(4);
        chk("t5_debounce_busy", bz(), 1);
        vif.mode = 1'b1;
        tick(1);
        chk("t5_abort_idle", bz(), 0);
        tick(10);
        chk("t5_abort_no_pulse", pc[2] - base, 0);
        vif.cand2_button = 1'b0;
        tick(3);
        vif.mode = 1'b0;
        tick(2);

        // 6. Asynchronous reset mid-debounce
        vif.cand4_button = 1'b1;
        tick(4);
        chk("t6_debounce_busy", bz(), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_busy", bz(), 0);
        chk("t6_async_valid", vv(), 0);
`ifdef VOTE_REJECT_CNT_EN
        chk("t6_reject_cleared", {24'd0, vif.reject_count}, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = pc[4];
        tick(6);
        chk("t6_pre_pulse", pc[4] - base, 0);
        tick(1);
        chk("t6_pulse", vv(), 8);
        tick(1);
        chk("t6_single_cycle", vv(), 0);
        vif.cand4_button = 1'b0;
        tick(8);
        chk("t6_idle", bz(), 0);

        chk("one_hot_valids", multi_hot, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
